// File: rtl/diff_pair_seq_if.sv
// Signal bundle around the paired-difference sequencer: enable and
// measurement strobe in, modulation reference, pair beats and statistics out.
interface diff_pair_seq_if #(
    parameter int W  = 20,
    parameter int CW = 16
);
    logic          en;
    logic          in_dval;
    logic [W-1:0]  in_data;
    logic          mod_out;
    logic          out_dval;
    logic [W-1:0]  out_data;
    logic          out_phase;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] pair_cnt;

    // Controller / TDC side: drives enable and samples, observes results.
    modport master (
        output en, in_dval, in_data,
        input  mod_out, out_dval, out_data, out_phase, drop_cnt, pair_cnt
    );

    // Sequencer side.
    modport slave (
        input  en, in_dval, in_data,
        output mod_out, out_dval, out_data, out_phase, drop_cnt, pair_cnt
    );
endinterface

// File: rtl/diff_pair_seq.sv
// Paired-difference sequencer.
// Generates the square-wave modulation reference, blanks measurements that
// land just after a phase edge, and pairs one clean sample from each half of
// the modulation period. A pair is forwarded as two consecutive beats (first
// sample, then second) tagged with the phase of the first sample. Samples
// that cannot be paired are counted in a saturating drop counter.
module diff_pair_seq #(
    parameter int W        = 20,
    parameter int DIV_HALF = 2500,
    parameter int BLANK    = 64,
    parameter int TIMEOUT  = 4000,
    parameter int CW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    diff_pair_seq_if.slave bus
);

    localparam int PW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] PH_LAST    = PW'(DIV_HALF - 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_A,
        S_WAIT_B,
        S_EMIT1,
        S_EMIT2
    } state_t;

    // Phase generator
    logic [PW-1:0] ph_cnt_q, ph_cnt_d;
    logic          mod_q, mod_d;
    logic [BW-1:0] blank_q, blank_d;

    // Pairing FSM
    state_t        state_q;
    logic [TW-1:0] tmo_q;
    logic [W-1:0]  a_data_q;
    logic          a_phase_q;
    logic [W-1:0]  b_data_q;
    logic          out_dval_q;
    logic [W-1:0]  out_data_q;
    logic          out_phase_q;

    // Statistics
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] pair_cnt_q, pair_cnt_d;
    logic [1:0]    drop_inc;
    logic          pair_inc;
    logic [CW:0]   drop_sum;

    // Sample screening
    logic toggle_now;
    logic blanked;
    logic smp_ok;
    logic smp_blk;
    logic same_phase;
    logic tmo_expire;

    // A toggle scheduled for the next cycle already counts as blanking: the
    // sample would otherwise straddle the phase edge.
    assign toggle_now = (ph_cnt_q == PH_LAST);
    assign blanked    = (blank_q != '0) || toggle_now;
    assign smp_ok     = bus.in_dval && !blanked;
    assign smp_blk    = bus.in_dval && blanked;
    assign same_phase = (mod_q == a_phase_q);
    assign tmo_expire = (tmo_q == TMO_LAST);

    // Next state of the half-period counter, modulation output and blank timer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        ph_cnt_d = ph_cnt_q + PW'(1);
        mod_d    = mod_q;
        blank_d  = (blank_q != '0) ? blank_q - BW'(1) : blank_q;
        if (!bus.en) begin
            ph_cnt_d = '0;
            mod_d    = 1'b0;
            blank_d  = BLANK_INIT;
        end else if (toggle_now) begin
            ph_cnt_d = '0;
            mod_d    = ~mod_q;
            blank_d  = BLANK_INIT;
        end
    end

    // Phase generator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_cnt_q <= '0;
            mod_q    <= 1'b0;
            blank_q  <= BLANK_INIT;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            ph_cnt_q <= ph_cnt_d;
            mod_q    <= mod_d;
            blank_q  <= blank_d;
        end
    end

    // Pairing FSM with registered beat outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            a_data_q    <= '0;
            a_phase_q   <= 1'b0;
            b_data_q    <= '0;
            out_dval_q  <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= 1'b0;
        end else if (!bus.en) begin
            // Disabling abandons any half-built pair without accounting it.
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            a_data_q    <= '0;
            a_phase_q   <= 1'b0;
            b_data_q    <= '0;
            out_dval_q  <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WAIT_A;
                end

                S_WAIT_A: begin
                    if (smp_ok) begin
                        a_data_q  <= bus.in_data;
                        a_phase_q <= mod_q;
                        tmo_q     <= '0;
                        state_q   <= S_WAIT_B;
                    end
                end

                S_WAIT_B: begin
                    if (smp_ok && !same_phase) begin
                        // Opposite-phase partner found; the first beat goes
                        // out next cycle, even if the timeout also expires now.
                        b_data_q    <= bus.in_data;
                        out_dval_q  <= 1'b1;
                        out_data_q  <= a_data_q;
                        out_phase_q <= a_phase_q;
                        state_q     <= S_EMIT1;
                    end else if (smp_ok) begin
                        // Same phase: the newer sample becomes the candidate.
                        a_data_q  <= bus.in_data;
                        a_phase_q <= mod_q;
                        tmo_q     <= '0;
                    end else if (tmo_expire) begin
                        state_q <= S_WAIT_A;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                S_EMIT1: begin
                    out_data_q <= b_data_q;
                    state_q    <= S_EMIT2;
                end

                S_EMIT2: begin
                    out_dval_q <= 1'b0;
                    state_q    <= S_WAIT_A;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Drop/pair event decode and saturating counter next state.
    always_comb begin
        drop_inc = 2'd0;
        pair_inc = 1'b0;
        if (bus.en) begin
            case (state_q)
                S_WAIT_A: drop_inc = {1'b0, smp_blk};
                S_WAIT_B: begin
                    if (smp_ok) begin
                        // A same-phase replacement orphans the stored sample.
                        drop_inc = {1'b0, same_phase};
                    end else begin
                        // A blanked sample and an expiring orphan can coincide.
                        drop_inc = {1'b0, smp_blk} + {1'b0, tmo_expire};
                    end
                end
                default: drop_inc = {1'b0, bus.in_dval};
            endcase
            pair_inc = (state_q == S_EMIT1);
        end

        drop_sum   = {1'b0, drop_cnt_q} + {{(CW - 1){1'b0}}, drop_inc};
        drop_cnt_d = drop_sum[CW] ? {CW{1'b1}} : drop_sum[CW-1:0];
        pair_cnt_d = (pair_inc && (pair_cnt_q != {CW{1'b1}}))
                   ? pair_cnt_q + CW'(1) : pair_cnt_q;
    end

    // Statistics counters; they survive a disable and clear only on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
            pair_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

    assign bus.mod_out   = mod_q;
    assign bus.out_dval  = out_dval_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_phase = out_phase_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_diff_pair_seq.sv
// Self-checking bench for diff_pair_seq. A cycle-indexed behavioural model
// predicts every output; a compare process checks the DUT against it on each
// falling edge, and directed scenarios pin key values with literals.
module tb_diff_pair_seq;

    localparam int W        = 20;
    localparam int CW       = 16;
    localparam int DIV_HALF = 16;
    localparam int BLANK    = 2;
    localparam int TIMEOUT  = 20;
    localparam int MAXC     = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    diff_pair_seq_if #(.W(W), .CW(CW)) bif ();

    diff_pair_seq #(
        .W       (W),
        .DIV_HALF(DIV_HALF),
        .BLANK   (BLANK),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    // m_k is the cycle index since enable rose; phase and blanking follow
    // from it arithmetically.
    bit           m_en_prev = 1'b0;
    int           m_k       = 0;
    bit           m_pend    = 1'b0;
    logic [W-1:0] m_a       = '0;
    logic [W-1:0] m_b       = '0;
    bit           m_p       = 1'b0;
    int           m_acc_k   = 0;
    int           m_emit    = 0;

    bit           e_mod   = 1'b0;
    bit           e_dval  = 1'b0;
    bit           e_phase = 1'b0;
    logic [W-1:0] e_data  = '0;
    int           e_drop  = 0;
    int           e_pair  = 0;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic int next_k();
        return m_en_prev ? m_k + 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model, advanced on every rising edge.
    initial begin : model
        int k;
        int drops;
        bit blk;
        bit ph;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_en_prev = 1'b0; m_pend = 1'b0; m_emit = 0;
                e_mod = 1'b0; e_dval = 1'b0; e_phase = 1'b0; e_data = '0;
                e_drop = 0; e_pair = 0;
            end else if (!bif.en) begin
                m_en_prev = 1'b0; m_pend = 1'b0; m_emit = 0;
                e_mod = 1'b0; e_dval = 1'b0; e_phase = 1'b0; e_data = '0;
            end else begin
                k = next_k();
                m_k = k;
                m_en_prev = 1'b1;
                blk = ((k % DIV_HALF) < BLANK) || ((k % DIV_HALF) == DIV_HALF - 1);
                ph  = ((k / DIV_HALF) % 2) == 1;
                drops = 0;
                if (k == 0) begin
                    if (bif.in_dval) drops = 1;
                end else if (m_emit == 1) begin
                    e_data = m_b;
                    e_pair = sat(e_pair + 1);
                    m_emit = 2;
                    if (bif.in_dval) drops = 1;
                end else if (m_emit == 2) begin
                    e_dval = 1'b0;
                    m_emit = 0;
                    if (bif.in_dval) drops = 1;
                end else if (!m_pend) begin
                    if (bif.in_dval) begin
                        if (blk) drops = 1;
                        else begin
                            m_pend = 1'b1; m_a = bif.in_data; m_p = ph; m_acc_k = k;
                        end
                    end
                end else begin
                    if (bif.in_dval && !blk && ph != m_p) begin
                        e_dval = 1'b1; e_data = m_a; e_phase = m_p;
                        m_b = bif.in_data; m_emit = 1; m_pend = 1'b0;
                    end else if (bif.in_dval && !blk) begin
                        drops = 1; m_a = bif.in_data; m_p = ph; m_acc_k = k;
                    end else begin
                        if (bif.in_dval) drops++;
                        if (k - m_acc_k >= TIMEOUT) begin
                            drops++;
                            m_pend = 1'b0;
                        end
                    end
                end
                e_drop = sat(e_drop + drops);
                e_mod  = (((k + 1) / DIV_HALF) % 2) == 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("mod_out",   32'(bif.mod_out),   32'(e_mod));
            check("out_dval",  32'(bif.out_dval),  32'(e_dval));
            check("out_data",  32'(bif.out_data),  32'(e_data));
            check("out_phase", 32'(bif.out_phase), 32'(e_phase));
            check("drop_cnt",  32'(bif.drop_cnt),  e_drop);
            check("pair_cnt",  32'(bif.pair_cnt),  e_pair);
        end
    end

    // Advance to the falling edge just before the rising edge of cycle kk.
    task automatic wait_next(input int kk);
        int n;
        n = 0;
        while (next_k() != kk && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_cycle", next_k(), kk);
    endtask

    // Present one sample in cycle kk; returns at the following falling edge.
    task automatic sample_at(input int kk, input logic [W-1:0] x);
        wait_next(kk);
        bif.in_dval = 1'b1;
        bif.in_data = x;
        @(negedge clk);
        bif.in_dval = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bif.en      = 1'b0;
        bif.in_dval = 1'b0;
        bif.in_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mod",  32'(bif.mod_out),  32'd0);
        check("rst_dval", 32'(bif.out_dval), 32'd0);
        check("rst_data", 32'(bif.out_data), 32'd0);
        check("rst_drop", 32'(bif.drop_cnt), 32'd0);
        check("rst_pair", 32'(bif.pair_cnt), 32'd0);

        rst    = 1'b1;
        bif.en = 1'b1;

        // Clean pair across the first rising edge of mod_out
        sample_at(5, 20'h00100);
        wait_next(15);
        check("mod_before_rise", 32'(bif.mod_out), 32'd0);
        wait_next(16);
        check("mod_first_rise", 32'(bif.mod_out), 32'd1);
        sample_at(19, 20'h00200);
        check("clean_b1_dval",  32'(bif.out_dval),  32'd1);
        check("clean_b1_data",  32'(bif.out_data),  32'h00100);
        check("clean_b1_phase", 32'(bif.out_phase), 32'd0);
        wait_next(21);
        check("clean_b2_dval",  32'(bif.out_dval),  32'd1);
        check("clean_b2_data",  32'(bif.out_data),  32'h00200);
        wait_next(22);
        check("clean_end_dval", 32'(bif.out_dval), 32'd0);
        check("clean_hold",     32'(bif.out_data), 32'h00200);
        check("clean_pair",     32'(bif.pair_cnt), 32'd1);
        check("clean_drop",     32'(bif.drop_cnt), 32'd0);

        // Same-phase replacement
        sample_at(50, 20'h00111);
        sample_at(55, 20'h00122);
        sample_at(66, 20'h00133);
        check("repl_b1_data",  32'(bif.out_data),  32'h00122);
        check("repl_b1_phase", 32'(bif.out_phase), 32'd1);
        check("repl_drop",     32'(bif.drop_cnt),  32'd1);
        wait_next(68);
        check("repl_b2_data",  32'(bif.out_data),  32'h00133);
        check("repl_b2_phase", 32'(bif.out_phase), 32'd1);
        wait_next(69);
        check("repl_pair", 32'(bif.pair_cnt), 32'd2);

        // Blanking: toggle cycle and one cycle after the edge
        sample_at(79, 20'h00AAA);
        sample_at(81, 20'h00BBB);
        wait_next(83);
        check("blank_drop", 32'(bif.drop_cnt), 32'd3);
        check("blank_dval", 32'(bif.out_dval), 32'd0);

        // Orphan timeout
        sample_at(90, 20'h000C0);
        wait_next(110);
        check("tmo_before", 32'(bif.drop_cnt), 32'd3);
        wait_next(111);
        check("tmo_after",  32'(bif.drop_cnt), 32'd4);

        // Sample arriving during EMIT1
        sample_at(116, 20'h00300);
        sample_at(131, 20'h00400);
        check("ovl_b1_data",  32'(bif.out_data),  32'h00300);
        check("ovl_b1_phase", 32'(bif.out_phase), 32'd1);
        sample_at(132, 20'h00555);
        check("ovl_b2_dval", 32'(bif.out_dval), 32'd1);
        check("ovl_b2_data", 32'(bif.out_data), 32'h00400);
        check("ovl_drop",    32'(bif.drop_cnt), 32'd5);
        check("ovl_pair",    32'(bif.pair_cnt), 32'd3);

        // Enable dropped while waiting for the second sample
        sample_at(140, 20'h00600);
        wait_next(145);
        bif.en = 1'b0;
        @(negedge clk);
        check("dis_mod",  32'(bif.mod_out),  32'd0);
        check("dis_dval", 32'(bif.out_dval), 32'd0);
        bif.in_dval = 1'b1;
        bif.in_data = 20'h00999;
        @(negedge clk);
        bif.in_dval = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_drop", 32'(bif.drop_cnt), 32'd5);
        check("dis_pair", 32'(bif.pair_cnt), 32'd3);
        bif.en = 1'b1;

        // Asynchronous reset in the middle of EMIT1
        sample_at(3, 20'h00700);
        sample_at(18, 20'h00800);
        check("pre_rst_dval", 32'(bif.out_dval), 32'd1);
        check("pre_rst_data", 32'(bif.out_data), 32'h00700);
        #2 rst = 1'b0;
        #1;
        check("async_dval", 32'(bif.out_dval), 32'd0);
        check("async_data", 32'(bif.out_data), 32'd0);
        check("async_drop", 32'(bif.drop_cnt), 32'd0);
        check("async_pair", 32'(bif.pair_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/diff_pair_seq.md
Name: diff_pair_seq

Overview:
- Sequences the paired-difference datapath.
- Generates the modulation phase reference and screens incoming TDC measurements.
- Samples that land inside a blanking window after each phase edge are discarded, as are orphaned or same-phase samples.
- Only phase-aligned pairs (one sample per opposite half-period) are forwarded as two back-to-back beats, tagged with the phase of the first beat, to the downstream differencer.

Parameters:
- W, 20: measurement data width.
- DIV_HALF, 2500: clk cycles per modulation half-period (50 MHz clk gives a 10 kHz mod_out).
- BLANK, 64: cycles after each mod_out edge during which samples are discarded.
- TIMEOUT, 4000: max cycles between the first and second sample of a pair.
- CW, 16: width of the statistics counters.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  sequencer enable
- in_dval  input  1  measurement strobe, one cycle per sample
- in_data  input  W  measurement value
- mod_out  output  1  modulation phase reference
- out_dval  output  1  pair beat valid
- out_data  output  W  pair beat data
- out_phase  output  1  mod_out phase of the pair's first sample; constant across both beats
- drop_cnt  output  CW  samples discarded, saturating
- pair_cnt  output  CW  pairs emitted, saturating

Behaviour:
- Reset (rst low, async): mod_out=0, out_dval=0, out_data=0, out_phase=0, drop_cnt=0, pair_cnt=0, state=IDLE, phase counter=0, blank counter=BLANK.
- en low: synchronously forces the same values as reset, except drop_cnt and pair_cnt, which hold. Samples are ignored and not counted.
- Phase generator (en high):
  - Counter runs 0..DIV_HALF-1.
  - At DIV_HALF-1, mod_out toggles next cycle, counter wraps to 0, blank counter reloads to BLANK.
  - Blank counter otherwise decrements to 0 and holds.
- Sample phase: a sample's phase is the mod_out value in its in_dval cycle.
- Blanked sample: blank counter != 0, or a toggle is scheduled in the same cycle (counter == DIV_HALF-1).
- States:
  - IDLE: enters WAIT_A on the first cycle with en high.
  - WAIT_A:
    - Non-blanked sample: store data and phase P, clear timeout counter, go to WAIT_B.
    - Blanked sample: drop it.
  - WAIT_B: timeout counter increments each cycle.
    - Non-blanked sample with phase != P: store as second sample, go to EMIT1.
    - Non-blanked sample with phase == P: replaces the stored first sample (new P, timeout cleared), drop_cnt+1.
    - Blanked sample: drop_cnt+1, state unchanged.
    - Timeout counter reaches TIMEOUT-1 with no accepted sample: drop_cnt+1 (the orphaned first sample), go to WAIT_A.
    - Timeout expiry and a valid second sample in the same cycle: the second sample wins and the pair is emitted.
  - EMIT1: out_dval=1, out_data=first sample, out_phase=P. Go to EMIT2.
  - EMIT2: out_dval=1, out_data=second sample, out_phase=P. pair_cnt+1. Go to WAIT_A.
  - Any in_dval during EMIT1/EMIT2: drop_cnt+1.
- Drop accounting: every dropped sample counts once, via drop_cnt+1.
- Latency: first beat is registered the cycle after the second sample is accepted; the two beats are consecutive.
- Output hold: out_data and out_phase hold their last value while out_dval=0.
- Counters: saturate at all-ones and do not wrap.
- en falling mid-pair: any stored sample is discarded silently and is not counted.
- No backpressure: the downstream block must accept two consecutive beats.

Test Plan:
- Bench parameters: DIV_HALF=16, BLANK=2, TIMEOUT=20.
- Phase generator: en=1 from reset -> mod_out toggles every 16 clk cycles; first rise at cycle 16 after en.
- Clean pair: sample 0x00100 at mod_out=0 (blank expired), then 0x00200 after mod_out=1 plus 3 cycles -> two beats 0x00100 then 0x00200, out_phase=0, pair_cnt=1, drop_cnt=0.
- Same-phase replace: 0x00111 then 0x00122 both at mod_out=1, then 0x00133 at mod_out=0 -> beats 0x00122, 0x00133, out_phase=1, drop_cnt=1.
- Blanking: sample 1 cycle after a toggle, and a sample in the toggle cycle itself -> both dropped, drop_cnt=2, state stays WAIT_A, no out_dval.
- Timeout and emit overlap: first sample, then no sample for 20 cycles -> drop_cnt=1, back in WAIT_A. Separately, a sample arriving during EMIT1 -> drop_cnt+1 and the pair output is unaffected.
- Reset/enable mid-pair: deassert en while in WAIT_B -> mod_out=0, no emission, counters hold. Assert rst low asynchronously mid-EMIT1 -> out_dval=0 immediately, counters 0.
